mult_sa_arb: RTL and testbench

//   Round-robin arbiter/sequencer sharing one mult_sa shift-add multiplier among
//   N requesters. Accepts one operand pair per transaction over valid/ready,

---
 rtl/mult_sa_arb.sv | 118 +++++++++++
 tb/tb_mult_sa_arb.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_sa_arb.sv
// Round-robin arbiter that shares one mult_sa multiplier among N_REQ clients.
// One transaction in flight: grant, issue pulse, wait for result, respond.
module mult_sa_arb #(
  parameter int N_REQ = 4,
  parameter int A_DW  = 8,
  parameter int B_DW  = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [N_REQ-1:0]        req_vld_i,
  output logic [N_REQ-1:0]        req_rdy_o,
  input  logic [N_REQ*A_DW-1:0]   req_a_i,
  input  logic [N_REQ*B_DW-1:0]   req_b_i,
  input  logic [2*N_REQ-1:0]      req_tc_mode_i,
  output logic [N_REQ-1:0]        rsp_vld_o,
  input  logic [N_REQ-1:0]        rsp_rdy_i,
  output logic [A_DW+B_DW-1:0]    rsp_c_o,
  output logic                    mul_en_po,
  output logic [A_DW-1:0]         mul_a_o,
  output logic [B_DW-1:0]         mul_b_o,
  output logic [1:0]              mul_tc_mode_o,
  input  logic                    mul_busy_i,
  input  logic                    mul_c_vld_i,
  input  logic [A_DW+B_DW-1:0]    mul_c_i,
  output logic                    busy_o,
  output logic                    err_o
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] ptr_q, gnt_q, win;
  logic          win_vld;
  logic          req_hs, rsp_hs;
  int            idx;

  // First valid slot scanning from ptr_q with wrap-around.
  always_comb begin
    win     = ptr_q;
    win_vld = 1'b0;
    idx     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!win_vld && req_vld_i[PW'(idx)]) begin
        win_vld = 1'b1;
        win     = PW'(idx);
      end
    end
  end

  assign req_hs = (state_q == IDLE) && win_vld;
  assign rsp_hs = (state_q == RESP) && rsp_rdy_i[gnt_q];

  always_comb begin
    req_rdy_o = '0;
    rsp_vld_o = '0;
    if (req_hs) req_rdy_o[win] = 1'b1;
    if (state_q == RESP) rsp_vld_o[gnt_q] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    mul_en_po = 1'b0;
    busy_o    = (state_q != IDLE);
    unique case (state_q)
      IDLE:  if (win_vld) state_d = ISSUE;
      ISSUE: begin
        if (!mul_busy_i) begin
          mul_en_po = 1'b1;
          state_d   = WAIT;
        end
      end
      WAIT:  if (mul_c_vld_i) state_d = RESP;
      RESP:  if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mul_a_o       <= '0;
      mul_b_o       <= '0;
      mul_tc_mode_o <= '0;
      gnt_q         <= '0;
      ptr_q         <= '0;
      rsp_c_o       <= '0;
      err_o         <= 1'b0;
    end else begin
      if (req_hs) begin
        mul_a_o       <= req_a_i[int'(win)*A_DW +: A_DW];
        mul_b_o       <= req_b_i[int'(win)*B_DW +: B_DW];
        mul_tc_mode_o <= req_tc_mode_i[int'(win)*2 +: 2];
        gnt_q         <= win;
      end
      if (mul_c_vld_i) begin
        if (state_q == WAIT) rsp_c_o <= mul_c_i;
        else                 err_o   <= 1'b1;
      end
      if (rsp_hs) begin
        ptr_q <= (gnt_q == PW'(N_REQ - 1)) ? '0 : gnt_q + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mult_sa_arb.sv
// Bench for mult_sa_arb with a behavioural shift-add multiplier stand-in.
// Directed table, hand-written corner sequences and randomized traffic.
module tb_mult_sa_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_vld, req_rdy, rsp_vld, rsp_rdy;
  logic [31:0] req_a;
  logic [15:0] req_b;
  logic [7:0]  req_tc;
  logic [11:0] rsp_c, mul_c;
  logic        mul_en, mul_busy, mul_c_vld, busy, err;
  logic [7:0]  mul_a;
  logic [3:0]  mul_b;
  logic [1:0]  mul_tc;

  logic [7:0]  a_v[4];
  logic [3:0]  b_v[4];
  logic [1:0]  tc_v[4];

  int checks = 0;
  int failures = 0;
  int ptr_model = 0;
  int lat = 4;
  int en_cnt = 0;
  logic noise_en = 1'b0;
  logic noise = 1'b0;
  logic spur = 1'b0;

  always #5 clk = ~clk;

  always_comb begin
    req_a  = '0;
    req_b  = '0;
    req_tc = '0;
    for (int k = 0; k < 4; k++) begin
      req_a[k*8 +: 8]  = a_v[k];
      req_b[k*4 +: 4]  = b_v[k];
      req_tc[k*2 +: 2] = tc_v[k];
    end
  end

  mult_sa_arb dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_vld_i(req_vld), .req_rdy_o(req_rdy),
    .req_a_i(req_a), .req_b_i(req_b), .req_tc_mode_i(req_tc),
    .rsp_vld_o(rsp_vld), .rsp_rdy_i(rsp_rdy), .rsp_c_o(rsp_c),
    .mul_en_po(mul_en), .mul_a_o(mul_a), .mul_b_o(mul_b),
    .mul_tc_mode_o(mul_tc), .mul_busy_i(mul_busy),
    .mul_c_vld_i(mul_c_vld), .mul_c_i(mul_c),
    .busy_o(busy), .err_o(err)
  );

  // tc bit 0 marks A signed, bit 1 marks B signed.
  function automatic logic [11:0] golden(logic [7:0] a, logic [3:0] b,
                                         logic [1:0] tc);
    int av, bv;
    av = tc[0] ? int'($signed(a)) : int'(a);
    bv = tc[1] ? int'($signed(b)) : int'(b);
    return 12'(av * bv);
  endfunction

  function automatic int pick(logic [3:0] mask, int ptr);
    for (int i = 0; i < 4; i++)
      if (mask[(ptr + i) % 4]) return (ptr + i) % 4;
    return -1;
  endfunction

  // Multiplier stand-in: busy for lat cycles after en, then one-cycle c_vld.
  logic        m_busy, m_vld;
  logic [11:0] m_c, m_pend;
  int          m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_vld  <= 1'b0;
      m_c    <= '0;
      m_pend <= '0;
      m_cnt  <= 0;
    end else begin
      m_vld <= 1'b0;
      if (m_busy) begin
        if (m_cnt <= 1) begin
          m_busy <= 1'b0;
          m_vld  <= 1'b1;
          m_c    <= m_pend;
        end
        m_cnt <= m_cnt - 1;
      end else if (mul_en) begin
        m_busy <= 1'b1;
        m_cnt  <= lat;
        m_pend <= golden(mul_a, mul_b, mul_tc);
      end
    end
  end

  assign mul_busy  = m_busy | noise;
  assign mul_c_vld = m_vld | spur;
  assign mul_c     = m_c;

  always @(posedge clk) begin
    noise <= noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
    if (mul_en) en_cnt <= en_cnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk)
    if (mul_en) chk("en_while_busy", 32'(mul_busy), 0);

  task automatic txn(input logic [3:0] mask, input int slot,
                     input logic [11:0] exp_c, input int hold,
                     input string nm);
    int n, e0;
    logic [3:0] oh;
    oh = 4'b0001 << slot;
    @(posedge clk); #1;
    e0 = en_cnt;
    req_vld = mask;
    @(negedge clk);
    n = 0;
    while (req_rdy == 4'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_grant"}, 32'(req_rdy), 32'(oh));
    @(posedge clk); #1;
    req_vld = '0;
    n = 0;
    while (rsp_vld == 4'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < hold; i++) begin
      rsp_rdy = ~oh;
      @(negedge clk);
      chk({nm, "_bp_vld"}, 32'(rsp_vld), 32'(oh));
      chk({nm, "_bp_c"}, 32'(rsp_c), 32'(exp_c));
      chk({nm, "_bp_rdy"}, 32'(req_rdy), 0);
    end
    chk({nm, "_rsp_vld"}, 32'(rsp_vld), 32'(oh));
    chk({nm, "_rsp_c"}, 32'(rsp_c), 32'(exp_c));
    chk({nm, "_en_pulses"}, 32'(en_cnt - e0), 1);
    rsp_rdy = oh;
    @(posedge clk); #1;
    rsp_rdy = '0;
    ptr_model = (slot + 1) % 4;
  endtask

  typedef struct {
    int         slot;
    logic [7:0] a;
    logic [3:0] b;
    logic [1:0] tc;
    logic [11:0] c;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int s, acc;
    logic [3:0] mask;

    tbl[0] = '{0, 8'd200, 4'd13, 2'b00, 12'd2600};
    tbl[1] = '{2, 8'hFF, 4'hF, 2'b11, 12'd1};
    tbl[2] = '{2, 8'hFF, 4'hF, 2'b01, 12'hFF1};
    tbl[3] = '{1, 8'h00, 4'hF, 2'b00, 12'h000};
    tbl[4] = '{3, 8'hFF, 4'hF, 2'b00, 12'hEF1};
    tbl[5] = '{1, 8'h80, 4'h8, 2'b11, 12'h400};
    tbl[6] = '{3, 8'h80, 4'h7, 2'b01, 12'hC80};
    tbl[7] = '{0, 8'h7F, 4'h8, 2'b10, 12'hC08};

    for (int k = 0; k < 4; k++) begin
      a_v[k]  = '0;
      b_v[k]  = '0;
      tc_v[k] = '0;
    end
    req_vld = '0;
    rsp_rdy = '0;
    rst_n   = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outs",
        {req_rdy, rsp_vld, rsp_c, mul_en, mul_a, busy, err},
        0);
    chk("reset_mul_bt", {mul_b, mul_tc}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // all slots valid from reset: 0,1,2,3,0
    for (int k = 0; k < 4; k++) begin
      a_v[k]  = 8'(10 * k + 3);
      b_v[k]  = 4'(k + 5);
      tc_v[k] = 2'b00;
    end
    txn(4'hF, 0, 12'd15, 0, "rr0");
    txn(4'hF, 1, 12'd78, 0, "rr1");
    txn(4'hF, 2, 12'd161, 0, "rr2");
    txn(4'hF, 3, 12'd264, 0, "rr3");
    txn(4'hF, 0, 12'd15, 0, "rr4");

    // ptr now 1; slot 1 alone moves it to 2, then 3 beats 1
    txn(4'b0010, 1, 12'd78, 0, "p2");
    txn(4'b1010, 3, 12'd264, 0, "p3");
    txn(4'b1010, 1, 12'd78, 0, "p1");

    for (int i = 0; i < 8; i++) begin
      s = tbl[i].slot;
      a_v[s]  = tbl[i].a;
      b_v[s]  = tbl[i].b;
      tc_v[s] = tbl[i].tc;
      txn(4'b0001 << s, s, tbl[i].c, 0, "tbl");
    end

    a_v[0] = 8'd200; b_v[0] = 4'd13; tc_v[0] = 2'b00;
    txn(4'b0001, 0, 12'd2600, 10, "bp");

    noise_en = 1'b1;
    for (int it = 0; it < 60; it++) begin
      for (int k = 0; k < 4; k++) begin
        a_v[k]  = 8'($urandom);
        b_v[k]  = 4'($urandom);
        tc_v[k] = 2'($urandom);
      end
      lat  = int'($urandom_range(1, 6));
      mask = 4'($urandom_range(1, 15));
      s    = pick(mask, ptr_model);
      txn(mask, s, golden(a_v[s], b_v[s], tc_v[s]),
          int'($urandom_range(0, 3)), "rnd");
    end
    noise_en = 1'b0;
    lat = 4;
    repeat (2) @(negedge clk);
    chk("err_clean", 32'(err), 0);

    // reset during WAIT discards the in-flight op
    a_v[1] = 8'd9; b_v[1] = 4'd9; tc_v[1] = 2'b00;
    @(posedge clk); #1;
    req_vld = 4'b0010;
    @(posedge clk); #1;
    req_vld = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("busy_in_wait", 32'(busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_outs",
        {req_rdy, rsp_vld, rsp_c, mul_en, mul_a, busy, err},
        0);
    chk("rst_mul_bt", {mul_b, mul_tc}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ptr_model = 0;
    acc = 0;
    repeat (8) begin
      @(negedge clk);
      acc = acc | int'(rsp_vld) | int'(busy);
    end
    chk("no_rsp_after_rst", 32'(acc), 0);

    @(posedge clk); #1;
    spur = 1'b1;
    @(posedge clk); #1;
    spur = 1'b0;
    @(negedge clk);
    chk("err_spurious", 32'(err), 1);
    chk("spur_no_rsp", 32'(rsp_vld), 0);

    for (int k = 0; k < 4; k++) begin
      a_v[k] = 8'd7; b_v[k] = 4'd3; tc_v[k] = 2'b00;
    end
    txn(4'hF, 0, 12'd21, 0, "post_rst_ptr0");
    chk("err_sticky", 32'(err), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
